// File: rtl/opendap_mailbox_ap_pkg.sv
// Shared definitions for the mailbox access port: register map, CSW layout, FSM states.
package opendap_mailbox_ap_pkg;

    // Register word addresses (A[7:2])
    localparam logic [5:0] AddrCsw    = 6'h00;
    localparam logic [5:0] AddrTxdata = 6'h01;
    localparam logic [5:0] AddrRxdata = 6'h02;
    localparam logic [5:0] AddrIdr    = 6'h3F;

    // CSW bit positions
    localparam int unsigned CswH2tFull     = 0;
    localparam int unsigned CswT2hNonempty = 1;
    localparam int unsigned CswFlush       = 2;
    localparam int unsigned CswH2tLvlLsb   = 8;
    localparam int unsigned CswT2hLvlLsb   = 16;
    localparam int unsigned CswErrSticky   = 31;

    typedef enum logic {
        StIdle,
        StBusy
    } acc_state_e;

endpackage

// File: rtl/opendap_mailbox_ap_if.sv
// DP-to-AP access bus: strobes and payload from the DP, completion status back from the AP.
interface opendap_mailbox_ap_if;
    logic [5:0]  dpacc_addr;
    logic [31:0] dpacc_wdata;
    logic        dpacc_wen;
    logic        dpacc_ren;
    logic        dpacc_abort;
    logic [31:0] dpacc_rdata;
    logic        dpacc_rdy;
    logic        dpacc_err;

    modport master (
        output dpacc_addr, dpacc_wdata, dpacc_wen, dpacc_ren, dpacc_abort,
        input  dpacc_rdata, dpacc_rdy, dpacc_err
    );

    modport slave (
        input  dpacc_addr, dpacc_wdata, dpacc_wen, dpacc_ren, dpacc_abort,
        output dpacc_rdata, dpacc_rdy, dpacc_err
    );
endinterface

// File: rtl/opendap_sync_fifo.sv
// Single-clock FIFO; one push and one pop per cycle, full/empty judged on the current count.
module opendap_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned LvlW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LvlW-1:0]  level_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == LvlW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop never frees room for a same-cycle push, and vice versa
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and count update; flush wins over any push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
            if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer/count state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage, no reset needed: contents only visible while non-empty
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/opendap_mailbox_ap.sv
// Mailbox Access Port: DP access responder fronting a host->target and a target->host FIFO.
module opendap_mailbox_ap
    import opendap_mailbox_ap_pkg::*;
#(
    parameter logic [10:0]  IDR_DESIGNER = 11'h7ff,
    parameter logic [3:0]   IDR_REVISION = 4'h0,
    parameter int unsigned  FIFO_DEPTH   = 4
) (
    input  logic                  swclk,
    input  logic                  rst_n_por,
    opendap_mailbox_ap_if.slave   dpacc,
    output logic [31:0]           h2t_data,
    output logic                  h2t_valid,
    input  logic                  h2t_ready,
    input  logic [31:0]           t2h_data,
    input  logic                  t2h_valid,
    output logic                  t2h_ready
);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] IdrVal = {IDR_REVISION, IDR_DESIGNER, 4'h0, 5'h0, 8'h01};

    acc_state_e  state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        write_q, write_d, conflict_q, conflict_d;
    logic        err_q, err_d, sticky_q, sticky_d;

    logic            h2t_push, h2t_full, h2t_empty, t2h_pop, t2h_full, t2h_empty, flush;
    logic [31:0]     t2h_head, csw_val;
    logic [LvlW-1:0] h2t_level, t2h_level;

    assign dpacc.dpacc_rdy   = (state_q == StIdle);
    assign dpacc.dpacc_err   = err_q;
    assign dpacc.dpacc_rdata = rdata_q;
    assign h2t_valid         = !h2t_empty;
    assign t2h_ready         = !t2h_full;

    // CSW read view
    always_comb begin
        csw_val                     = '0;
        csw_val[CswH2tFull]         = h2t_full;
        csw_val[CswT2hNonempty]     = !t2h_empty;
        csw_val[CswH2tLvlLsb +: 5]  = 5'(h2t_level);
        csw_val[CswT2hLvlLsb +: 5]  = 5'(t2h_level);
        csw_val[CswErrSticky]       = sticky_q;
    end

    // Access FSM: latch in IDLE, commit side effects in BUSY
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        conflict_d = conflict_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        sticky_d   = sticky_q;
        h2t_push   = 1'b0;
        t2h_pop    = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dpacc.dpacc_wen || dpacc.dpacc_ren) begin
                    state_d    = StBusy;
                    addr_d     = dpacc.dpacc_addr;
                    wdata_d    = dpacc.dpacc_wdata;
                    write_d    = dpacc.dpacc_wen;
                    conflict_d = dpacc.dpacc_wen && dpacc.dpacc_ren;
                end
            end
            StBusy: begin
                state_d = StIdle;
                rdata_d = '0;
                err_d   = 1'b0;
                if (dpacc.dpacc_abort) begin
                    // cancelled: no side effect
                end else if (conflict_q) begin
                    err_d = 1'b1;
                end else if (write_q) begin
                    unique case (addr_q)
                        AddrCsw: begin
                            flush = wdata_q[CswFlush];
                            if (wdata_q[CswErrSticky]) sticky_d = 1'b0;
                        end
                        AddrTxdata: begin
                            if (h2t_full) begin
                                err_d    = 1'b1;
                                sticky_d = 1'b1;
                            end else begin
                                h2t_push = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    unique case (addr_q)
                        AddrCsw: rdata_d = csw_val;
                        AddrRxdata: begin
                            if (t2h_empty) begin
                                err_d    = 1'b1;
                                sticky_d = 1'b1;
                            end else begin
                                rdata_d = t2h_head;
                                t2h_pop = 1'b1;
                            end
                        end
                        AddrIdr: rdata_d = IdrVal;
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Access state register
    always_ff @(posedge swclk or negedge rst_n_por) begin
        if (!rst_n_por) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            conflict_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            conflict_q <= conflict_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
        end
    end

    opendap_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_h2t_fifo (
        .clk_i   (swclk),
        .rst_ni  (rst_n_por),
        .push_i  (h2t_push),
        .data_i  (wdata_q),
        .pop_i   (h2t_ready),
        .flush_i (flush),
        .data_o  (h2t_data),
        .full_o  (h2t_full),
        .empty_o (h2t_empty),
        .level_o (h2t_level)
    );

    opendap_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_t2h_fifo (
        .clk_i   (swclk),
        .rst_ni  (rst_n_por),
        .push_i  (t2h_valid),
        .data_i  (t2h_data),
        .pop_i   (t2h_pop),
        .flush_i (flush),
        .data_o  (t2h_head),
        .full_o  (t2h_full),
        .empty_o (t2h_empty),
        .level_o (t2h_level)
    );
endmodule

// File: tb/tb_opendap_mailbox_ap.sv
// Directed bench for the mailbox access port.
module tb_opendap_mailbox_ap;
    import opendap_mailbox_ap_pkg::*;

    logic        swclk = 1'b0;
    logic        rst_n_por = 1'b0;
    logic [31:0] h2t_data;
    logic        h2t_valid;
    logic        h2t_ready = 1'b0;
    logic [31:0] t2h_data = '0;
    logic        t2h_valid = 1'b0;
    logic        t2h_ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rd;
    logic        er;
    int          bc;

    opendap_mailbox_ap_if bus ();

    opendap_mailbox_ap #(
        .IDR_DESIGNER (11'h7ff),
        .IDR_REVISION (4'h0),
        .FIFO_DEPTH   (4)
    ) dut (
        .swclk     (swclk),
        .rst_n_por (rst_n_por),
        .dpacc     (bus.slave),
        .h2t_data  (h2t_data),
        .h2t_valid (h2t_valid),
        .h2t_ready (h2t_ready),
        .t2h_data  (t2h_data),
        .t2h_valid (t2h_valid),
        .t2h_ready (t2h_ready)
    );

    always #5 swclk = ~swclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One complete access; returns rdata/err and number of cycles rdy was low
    task automatic dap_access(input logic wr, input logic [5:0] a, input logic [31:0] d,
                              output logic [31:0] r, output logic e, output int busy);
        @(negedge swclk);
        bus.dpacc_addr  = a;
        bus.dpacc_wdata = d;
        bus.dpacc_wen   = wr;
        bus.dpacc_ren   = !wr;
        @(negedge swclk);
        bus.dpacc_wen = 1'b0;
        bus.dpacc_ren = 1'b0;
        busy = 0;
        while (!bus.dpacc_rdy && busy < 20) begin
            busy++;
            @(negedge swclk);
        end
        r = bus.dpacc_rdata;
        e = bus.dpacc_err;
    endtask

    initial begin
        bus.dpacc_addr  = '0;
        bus.dpacc_wdata = '0;
        bus.dpacc_wen   = 1'b0;
        bus.dpacc_ren   = 1'b0;
        bus.dpacc_abort = 1'b0;
        repeat (2) @(negedge swclk);
        rst_n_por = 1'b1;

        // Reset state
        chk("rst_rdy", 32'(bus.dpacc_rdy), 32'd1);
        chk("rst_err", 32'(bus.dpacc_err), 32'd0);
        chk("rst_rdata", bus.dpacc_rdata, 32'h0);
        chk("rst_h2t_valid", 32'(h2t_valid), 32'd0);
        chk("rst_t2h_ready", 32'(t2h_ready), 32'd1);

        // IDR: {rev 0, designer 7ff at [27:17], 0, 0, 01}
        dap_access(1'b0, AddrIdr, '0, rd, er, bc);
        chk("idr_rdata", rd, 32'h0FFE_0001);
        chk("idr_err", 32'(er), 32'd0);
        chk("idr_busy_cycles", 32'(bc), 32'd1);

        // Fill H2T with target not ready
        for (int i = 1; i <= 4; i++) begin
            dap_access(1'b1, AddrTxdata, 32'h11 * i, rd, er, bc);
            chk("tx_fill_err", 32'(er), 32'd0);
        end
        dap_access(1'b0, AddrCsw, '0, rd, er, bc);
        chk("csw_h2t_full", rd, 32'h0000_0401);
        dap_access(1'b1, AddrTxdata, 32'h55, rd, er, bc);
        chk("tx_overflow_err", 32'(er), 32'd1);
        dap_access(1'b0, AddrCsw, '0, rd, er, bc);
        chk("csw_sticky_set", rd, 32'h8000_0401);

        // Target drains H2T in order
        h2t_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("h2t_valid_drain", 32'(h2t_valid), 32'd1);
            chk("h2t_data_order", h2t_data, 32'h11 * i);
            @(negedge swclk);
        end
        chk("h2t_drained", 32'(h2t_valid), 32'd0);
        h2t_ready = 1'b0;

        // Target pushes one message into T2H
        t2h_data  = 32'hA5A5_A5A5;
        t2h_valid = 1'b1;
        @(negedge swclk);
        t2h_valid = 1'b0;
        dap_access(1'b0, AddrCsw, '0, rd, er, bc);
        chk("csw_t2h_one", rd, 32'h8001_0002);
        dap_access(1'b0, AddrRxdata, '0, rd, er, bc);
        chk("rx_data", rd, 32'hA5A5_A5A5);
        chk("rx_err", 32'(er), 32'd0);
        dap_access(1'b0, AddrRxdata, '0, rd, er, bc);
        chk("rx_empty_rdata", rd, 32'h0);
        chk("rx_empty_err", 32'(er), 32'd1);

        // Abort a TXDATA write during BUSY
        @(negedge swclk);
        bus.dpacc_addr  = AddrTxdata;
        bus.dpacc_wdata = 32'h66;
        bus.dpacc_wen   = 1'b1;
        @(negedge swclk);
        bus.dpacc_wen   = 1'b0;
        bus.dpacc_abort = 1'b1;
        chk("abort_busy", 32'(bus.dpacc_rdy), 32'd0);
        @(negedge swclk);
        bus.dpacc_abort = 1'b0;
        chk("abort_rdy", 32'(bus.dpacc_rdy), 32'd1);
        chk("abort_err", 32'(bus.dpacc_err), 32'd0);
        chk("abort_no_push", 32'(h2t_valid), 32'd0);

        // Full H2T, target pop in the host commit cycle: still an overflow
        for (int i = 1; i <= 4; i++) dap_access(1'b1, AddrTxdata, 32'(i), rd, er, bc);
        @(negedge swclk);
        bus.dpacc_addr  = AddrTxdata;
        bus.dpacc_wdata = 32'h99;
        bus.dpacc_wen   = 1'b1;
        @(negedge swclk);
        bus.dpacc_wen = 1'b0;
        h2t_ready     = 1'b1;
        @(negedge swclk);
        h2t_ready = 1'b0;
        chk("race_rdy", 32'(bus.dpacc_rdy), 32'd1);
        chk("race_err", 32'(bus.dpacc_err), 32'd1);
        chk("race_head", h2t_data, 32'd2);
        dap_access(1'b0, AddrCsw, '0, rd, er, bc);
        chk("csw_race_level3", rd, 32'h8000_0300);

        // Put something in T2H too, then flush both and clear sticky
        t2h_data  = 32'h77;
        t2h_valid = 1'b1;
        @(negedge swclk);
        t2h_valid = 1'b0;
        dap_access(1'b1, AddrCsw, 32'h8000_0004, rd, er, bc);
        chk("csw_flush_err", 32'(er), 32'd0);
        dap_access(1'b0, AddrCsw, '0, rd, er, bc);
        chk("csw_after_flush", rd, 32'h0000_0000);

        // Conflicting strobes: error, no side effect
        @(negedge swclk);
        bus.dpacc_addr  = AddrTxdata;
        bus.dpacc_wdata = 32'hEE;
        bus.dpacc_wen   = 1'b1;
        bus.dpacc_ren   = 1'b1;
        @(negedge swclk);
        bus.dpacc_wen = 1'b0;
        bus.dpacc_ren = 1'b0;
        @(negedge swclk);
        chk("conflict_err", 32'(bus.dpacc_err), 32'd1);
        chk("conflict_no_push", 32'(h2t_valid), 32'd0);

        // Strobes during BUSY are ignored
        @(negedge swclk);
        bus.dpacc_addr  = AddrTxdata;
        bus.dpacc_wdata = 32'hCD;
        bus.dpacc_wen   = 1'b1;
        @(negedge swclk);
        bus.dpacc_wen  = 1'b0;
        bus.dpacc_addr = AddrRxdata;
        bus.dpacc_ren  = 1'b1;
        @(negedge swclk);
        bus.dpacc_ren = 1'b0;
        chk("busy_strobe_rdy", 32'(bus.dpacc_rdy), 32'd1);
        chk("busy_strobe_err", 32'(bus.dpacc_err), 32'd0);
        @(negedge swclk);
        chk("busy_strobe_not_taken", 32'(bus.dpacc_rdy), 32'd1);
        dap_access(1'b0, AddrCsw, '0, rd, er, bc);
        chk("csw_one_push", rd, 32'h0000_0100);

        // Reset while BUSY
        @(negedge swclk);
        bus.dpacc_addr  = AddrTxdata;
        bus.dpacc_wdata = 32'hAB;
        bus.dpacc_wen   = 1'b1;
        @(negedge swclk);
        bus.dpacc_wen = 1'b0;
        rst_n_por     = 1'b0;
        #1;
        chk("rst_busy_rdy", 32'(bus.dpacc_rdy), 32'd1);
        chk("rst_busy_h2t_empty", 32'(h2t_valid), 32'd0);
        @(negedge swclk);
        rst_n_por = 1'b1;
        dap_access(1'b0, AddrCsw, '0, rd, er, bc);
        chk("csw_after_reset", rd, 32'h0000_0000);
        chk("csw_after_reset_busy", 32'(bc), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
